// File: rtl/fp_mul_pkg.sv
// Shared floating-point definitions: operand classes, result kinds, bias and
// canonical quiet-NaN encoding pieces, reused by the FP arithmetic blocks.
package fp_mul_pkg;

   // Operand classification after decode
   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_NORMAL,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   // What the final stage has to pack: a computed number or a fixed special
   typedef enum logic [1:0] {
      RES_NUM,
      RES_ZERO,
      RES_INF,
      RES_NAN
   } res_kind_e;

   // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only
   localparam logic CANON_NAN_SIGN = 1'b0;
   localparam logic CANON_NAN_QBIT = 1'b1;

   // Exponent bias for an exponent field of exp_w bits
   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Width-independent classifier; subnormals are treated as zero
   function automatic fp_class_e fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic man_zero,
                                             input logic man_msb);
      if (exp_zero) return CLS_ZERO;
      if (!exp_ones) return CLS_NORMAL;
      if (man_zero) return CLS_INF;
      if (man_msb) return CLS_QNAN;
      return CLS_SNAN;
   endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Final multiplier stage logic: normalise the raw mantissa product, round to
// nearest-even, detect exponent overflow/underflow and pack the result word.
module fp_round_norm
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     sign_i,
   input  res_kind_e                kind_i,
   input  logic                     invalid_i,
   input  logic [2*MAN_W+1:0]       prod_i,
   input  logic signed [EXP_W+1:0]  exp_i,
   output logic [EXP_W+MAN_W:0]     word_o,
   output logic                     invalid_o,
   output logic                     overflow_o,
   output logic                     underflow_o
);
   localparam int PW = 2 * MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] ONE_E   = EW'(1);
   localparam logic signed [EW-1:0] ZERO_E  = '0;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

   logic [PW-2:0]          prod_n;
   logic signed [EW-1:0]   exp_n;
   logic signed [EW-1:0]   exp_r;
   logic [MAN_W-1:0]       man_t;
   logic                   guard_b;
   logic                   sticky_b;
   logic                   lsb_b;
   logic                   round_up;
   logic [MAN_W:0]         man_sum;

   // Normalise so the hidden bit sits just above the kept mantissa, then round
   always_comb begin
      prod_n      = prod_i[PW-1] ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
      exp_n       = prod_i[PW-1] ? exp_i + ONE_E : exp_i;
      man_t       = prod_n[PW-2 -: MAN_W];
      lsb_b       = prod_n[MAN_W+1];
      guard_b     = prod_n[MAN_W];
      sticky_b    = |prod_n[MAN_W-1:0];
      round_up    = guard_b & (sticky_b | lsb_b);
      man_sum     = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
      // A carry out of the mantissa leaves it all-zero and bumps the exponent
      exp_r       = man_sum[MAN_W] ? exp_n + ONE_E : exp_n;

      word_o      = '0;
      invalid_o   = invalid_i;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;
      case (kind_i)
         RES_NAN:  word_o = {CANON_NAN_SIGN, {EXP_W{1'b1}}, CANON_NAN_QBIT, {(MAN_W-1){1'b0}}};
         RES_INF:  word_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         RES_ZERO: word_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
         default: begin
            if (exp_r >= EXP_MAX) begin
               word_o     = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               overflow_o = 1'b1;
            end else if (exp_r <= ZERO_E) begin
               word_o      = {sign_i, {(EXP_W+MAN_W){1'b0}}};
               underflow_o = 1'b1;
            end else begin
               word_o = {sign_i, exp_r[EXP_W-1:0], man_sum[MAN_W-1:0]};
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// S1 decodes and classifies, S2 multiplies mantissas and sums exponents,
// S3 normalises, rounds and packs. All stages advance on a single enable.
module fp_mul_pipe
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [EXP_W+MAN_W:0]  data_iA,
   input  logic [EXP_W+MAN_W:0]  data_iB,
   input  logic                  Valid_In,
   output logic                  Ready_In,
   output logic [EXP_W+MAN_W:0]  data_o,
   output logic                  Valid_Out,
   input  logic                  Ready_Out,
   output logic                  flag_invalid,
   output logic                  flag_overflow,
   output logic                  flag_underflow
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 2;
   localparam int MW = MAN_W + 1;
   localparam int PW = 2 * MAN_W + 2;
   localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP_W));

   logic                 en;
   fp_class_e            cls_a, cls_b;
   logic                 inf_zero;
   logic                 nan_in;

   // Stage 1 state
   logic                 v1_d, v1_q, sign1_d, sign1_q, inv1_d, inv1_q;
   res_kind_e            kind1_d, kind1_q;
   logic [EXP_W-1:0]     ea1_d, ea1_q, eb1_d, eb1_q;
   logic [MW-1:0]        ma1_d, ma1_q, mb1_d, mb1_q;
   // Stage 2 state
   logic                 v2_d, v2_q, sign2_d, sign2_q, inv2_d, inv2_q;
   res_kind_e            kind2_d, kind2_q;
   logic [PW-1:0]        prod2_d, prod2_q;
   logic signed [EW-1:0] exp2_d, exp2_q;
   // Stage 3 state
   logic                 v3_d, v3_q;
   logic [W-1:0]         word3_d, word3_q, word_rn;
   logic                 inv3_d, inv3_q, ovf3_d, ovf3_q, unf3_d, unf3_q;
   logic                 rn_inv, rn_ovf, rn_unf;

   // The whole pipe moves unless a finished result is waiting on downstream
   assign en       = ~v3_q | Ready_Out;
   assign Ready_In = en;

   // S1: classify both operands and decide whether the result is a special
   always_comb begin
      cls_a    = fp_classify(data_iA[W-2 -: EXP_W] == '0, &data_iA[W-2 -: EXP_W],
                             data_iA[MAN_W-1:0] == '0, data_iA[MAN_W-1]);
      cls_b    = fp_classify(data_iB[W-2 -: EXP_W] == '0, &data_iB[W-2 -: EXP_W],
                             data_iB[MAN_W-1:0] == '0, data_iB[MAN_W-1]);
      inf_zero = (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                 (cls_a == CLS_ZERO && cls_b == CLS_INF);
      nan_in   = (cls_a == CLS_QNAN) || (cls_a == CLS_SNAN) ||
                 (cls_b == CLS_QNAN) || (cls_b == CLS_SNAN);
      v1_d     = Valid_In;
      sign1_d  = data_iA[W-1] ^ data_iB[W-1];
      inv1_d   = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN) || inf_zero;
      ea1_d    = data_iA[W-2 -: EXP_W];
      eb1_d    = data_iB[W-2 -: EXP_W];
      ma1_d    = {1'b1, data_iA[MAN_W-1:0]};
      mb1_d    = {1'b1, data_iB[MAN_W-1:0]};
      if (nan_in || inf_zero)
         kind1_d = RES_NAN;
      else if (cls_a == CLS_INF || cls_b == CLS_INF)
         kind1_d = RES_INF;
      else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
         kind1_d = RES_ZERO;
      else
         kind1_d = RES_NUM;
   end

   // S2: full-width mantissa product and biased exponent sum
   always_comb begin
      v2_d    = v1_q;
      sign2_d = sign1_q;
      inv2_d  = inv1_q;
      kind2_d = kind1_q;
      prod2_d = {{MW{1'b0}}, ma1_q} * {{MW{1'b0}}, mb1_q};
      exp2_d  = $signed({2'b00, ea1_q}) + $signed({2'b00, eb1_q}) - BIAS_S;
   end

   fp_round_norm #(
      .EXP_W       (EXP_W),
      .MAN_W       (MAN_W)
   ) u_round_norm (
      .sign_i      (sign2_q),
      .kind_i      (kind2_q),
      .invalid_i   (inv2_q),
      .prod_i      (prod2_q),
      .exp_i       (exp2_q),
      .word_o      (word_rn),
      .invalid_o   (rn_inv),
      .overflow_o  (rn_ovf),
      .underflow_o (rn_unf)
   );

   // S3: capture packed result; flags are forced low for bubbles
   always_comb begin
      v3_d    = v2_q;
      word3_d = word_rn;
      inv3_d  = v2_q & rn_inv;
      ovf3_d  = v2_q & rn_ovf;
      unf3_d  = v2_q & rn_unf;
   end

   // Advance all three stages together; reset empties the pipe
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;  sign1_q <= 1'b0;  inv1_q <= 1'b0;  kind1_q <= RES_NUM;
         ea1_q   <= '0;    eb1_q   <= '0;    ma1_q  <= '0;    mb1_q   <= '0;
         v2_q    <= 1'b0;  sign2_q <= 1'b0;  inv2_q <= 1'b0;  kind2_q <= RES_NUM;
         prod2_q <= '0;    exp2_q  <= '0;
         v3_q    <= 1'b0;  word3_q <= '0;
         inv3_q  <= 1'b0;  ovf3_q  <= 1'b0;  unf3_q <= 1'b0;
      end else if (en) begin
         v1_q    <= v1_d;  sign1_q <= sign1_d;  inv1_q <= inv1_d;  kind1_q <= kind1_d;
         ea1_q   <= ea1_d; eb1_q   <= eb1_d;    ma1_q  <= ma1_d;   mb1_q   <= mb1_d;
         v2_q    <= v2_d;  sign2_q <= sign2_d;  inv2_q <= inv2_d;  kind2_q <= kind2_d;
         prod2_q <= prod2_d;
         exp2_q  <= exp2_d;
         v3_q    <= v3_d;  word3_q <= word3_d;
         inv3_q  <= inv3_d; ovf3_q <= ovf3_d;   unf3_q <= unf3_d;
      end
   end

   assign Valid_Out      = v3_q;
   assign data_o         = word3_q;
   assign flag_invalid   = inv3_q;
   assign flag_overflow  = ovf3_q;
   assign flag_underflow = unf3_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (single precision). Expected results
// {invalid, overflow, underflow, word} are queued when an operand pair is
// accepted and compared when the pipe hands a result downstream.
`timescale 1ns/1ps
module tb_fp_mul_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_iA = '0;
   logic [31:0] data_iB = '0;
   logic        Valid_In = 1'b0;
   logic        Ready_In;
   logic [31:0] data_o;
   logic        Valid_Out;
   logic        Ready_Out = 1'b1;
   logic        flag_invalid, flag_overflow, flag_underflow;

   int          checks  = 0;
   int          errors  = 0;
   int          out_cnt = 0;
   int          cyc     = 0;
   logic [34:0] sb_q[$];
   logic [34:0] mon_exp;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_iA        (data_iA),
      .data_iB        (data_iB),
      .Valid_In       (Valid_In),
      .Ready_In       (Ready_In),
      .data_o         (data_o),
      .Valid_Out      (Valid_Out),
      .Ready_Out      (Ready_Out),
      .flag_invalid   (flag_invalid),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: pop and compare on every downstream transfer
   always @(negedge clk) begin
      if (!rst) begin
         if (Valid_Out && Ready_Out) begin
            checks++;
            out_cnt++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result got=%h flags=%b required=none",
                        data_o, {flag_invalid, flag_overflow, flag_underflow});
            end else begin
               mon_exp = sb_q.pop_front();
               if ({flag_invalid, flag_overflow, flag_underflow, data_o} !== mon_exp) begin
                  errors++;
                  $display("FAIL result got=%h flags=%b required=%h flags=%b",
                           data_o, {flag_invalid, flag_overflow, flag_underflow},
                           mon_exp[31:0], mon_exp[34:32]);
               end else begin
                  $display("result %h flags=%b ok", data_o,
                           {flag_invalid, flag_overflow, flag_underflow});
               end
            end
         end
         if (!Valid_Out) begin
            checks++;
            if ({flag_invalid, flag_overflow, flag_underflow} !== 3'b000) begin
               errors++;
               $display("FAIL flags_idle got=%b required=000",
                        {flag_invalid, flag_overflow, flag_underflow});
            end
         end
      end
   end

   // Reference single-precision multiply: FTZ inputs, RNE, no subnormal output
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
      logic              s;
      logic [7:0]        ea, eb;
      logic [22:0]       fa, fb;
      logic              nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
      longint unsigned   p, m, rem, half;
      int                e, sh;
      s  = a[31] ^ b[31];
      ea = a[30:23]; eb = b[30:23];
      fa = a[22:0];  fb = b[22:0];
      nan_a  = (ea == 8'hFF) && (fa != 0);
      nan_b  = (eb == 8'hFF) && (fb != 0);
      snan_a = nan_a && !fa[22];
      snan_b = nan_b && !fb[22];
      inf_a  = (ea == 8'hFF) && (fa == 0);
      inf_b  = (eb == 8'hFF) && (fb == 0);
      zero_a = (ea == 8'h00);
      zero_b = (eb == 8'h00);
      if (nan_a || nan_b) return {snan_a || snan_b, 2'b00, 32'h7FC00000};
      if ((inf_a && zero_b) || (zero_a && inf_b)) return {3'b100, 32'h7FC00000};
      if (inf_a || inf_b) return {3'b000, s, 8'hFF, 23'h0};
      if (zero_a || zero_b) return {3'b000, s, 31'h0};
      p  = {40'd0, 1'b1, fa} * {40'd0, 1'b1, fb};
      e  = int'(ea) + int'(eb) - 127;
      sh = 23;
      if (p[47]) begin
         sh = 24;
         e  = e + 1;
      end
      m    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
      if (e <= 0) return {3'b001, s, 31'h0};
      return {3'b000, s, 8'(e), m[22:0]};
   endfunction

   // Random operand with a mix of classes and extreme exponents
   function automatic logic [31:0] rand_op();
      int unsigned r;
      logic [22:0] f;
      logic        s;
      r = $urandom_range(0, 11);
      f = 23'($urandom);
      s = 1'($urandom);
      case (r)
         0:       return {s, 8'h00, f};
         1:       return {s, 8'hFF, 23'h0};
         2:       return {s, 8'hFF, 1'b1, f[21:0]};
         3:       return {s, 8'hFF, 1'b0, f[21:0] | 22'h1};
         4:       return {s, 8'($urandom_range(200, 254)), f};
         5:       return {s, 8'($urandom_range(1, 60)), f};
         default: return {s, 8'($urandom_range(90, 165)), f};
      endcase
   endfunction

   // Present one operand pair until accepted; queue its expected result
   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [34:0] expv, output bit ok);
      data_iA  = a;
      data_iB  = b;
      Valid_In = 1'b1;
      ok       = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (Ready_In) begin
            sb_q.push_back(expv);
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
   endtask

   // Wait (bounded) for every queued result to come out
   task automatic drain(input int max_cyc, output bit ok);
      for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      ok = (sb_q.size() == 0);
   endtask

   task automatic test_reset();
      rst = 1'b1; Valid_In = 1'b0; Ready_Out = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (Valid_Out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", Valid_Out); end
      checks++;
      if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h required=00000000", data_o); end
      checks++;
      if ({flag_invalid, flag_overflow, flag_underflow} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got=%b required=000", {flag_invalid, flag_overflow, flag_underflow});
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (Ready_In !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b required=1", Ready_In); end
      $display("test_reset done");
   endtask

   task automatic test_latency();
      bit ok, dok;
      int lat;
      send(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000}, ok);
      Valid_In = 1'b0;
      lat = 1;
      while (Valid_Out !== 1'b1 && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (!ok || lat != 3) begin errors++; $display("FAIL latency got=%0d accepted=%b required=3", lat, ok); end
      checks++;
      if ({flag_invalid, flag_overflow, flag_underflow, data_o} !== {3'b000, 32'h40400000}) begin
         errors++;
         $display("FAIL latency_data got=%h flags=%b required=40400000 flags=000",
                  data_o, {flag_invalid, flag_overflow, flag_underflow});
      end
      drain(20, dok);
      checks++;
      if (!dok) begin errors++; $display("FAIL latency_drain pending=%0d required=0", sb_q.size()); end
      $display("test_latency latency=%0d", lat);
   endtask

   task automatic test_directed();
      logic [31:0] va [0:6];
      logic [31:0] vb [0:6];
      logic [34:0] ve [0:6];
      bit ok, dok;
      int to = 0;
      va = '{32'h3F800001, 32'h3F800800, 32'h00000000, 32'h7F800000,
             32'hFF800000, 32'h7F000000, 32'h00800000};
      vb = '{32'h3F800001, 32'h3F800800, 32'hC0000000, 32'h00000000,
             32'h40000000, 32'h7F000000, 32'h00800000};
      ve = '{{3'b000, 32'h3F800002}, {3'b000, 32'h3F801000}, {3'b000, 32'h80000000},
             {3'b100, 32'h7FC00000}, {3'b000, 32'hFF800000}, {3'b010, 32'h7F800000},
             {3'b001, 32'h00000000}};
      for (int i = 0; i < 7; i++) begin
         send(va[i], vb[i], ve[i], ok);
         if (!ok) to++;
      end
      Valid_In = 1'b0;
      drain(30, dok);
      checks++;
      if (to != 0 || !dok) begin
         errors++;
         $display("FAIL directed_flow timeouts=%0d pending=%0d required=0/0", to, sb_q.size());
      end
      $display("test_directed done");
   endtask

   task automatic test_back_to_back();
      bit ok, dok;
      int to = 0, start, out0;
      logic [31:0] a, b;
      Ready_Out = 1'b1;
      start = cyc;
      out0  = out_cnt;
      for (int i = 0; i < 40; i++) begin
         a = rand_op();
         b = rand_op();
         send(a, b, model(a, b), ok);
         if (!ok) to++;
      end
      checks++;
      if (to != 0 || cyc - start != 40) begin
         errors++;
         $display("FAIL input_rate cycles=%0d timeouts=%0d required=40/0", cyc - start, to);
      end
      Valid_In = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_cnt - out0 != 40) begin
         errors++;
         $display("FAIL output_rate got=%0d results required=40", out_cnt - out0);
      end
      drain(20, dok);
      checks++;
      if (!dok) begin errors++; $display("FAIL b2b_drain pending=%0d required=0", sb_q.size()); end
      $display("test_back_to_back done");
   endtask

   task automatic test_backpressure();
      bit ok, dok;
      int to = 0, out0;
      logic [31:0] a, b;
      logic [34:0] held;
      Ready_Out = 1'b1;
      out0 = out_cnt;
      for (int i = 0; i < 5; i++) begin
         a = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
         b = {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
         send(a, b, model(a, b), ok);
         if (!ok) to++;
      end
      Valid_In  = 1'b0;
      Ready_Out = 1'b0;
      #1;
      held = {flag_invalid, flag_overflow, flag_underflow, data_o};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (Valid_Out !== 1'b1 || Ready_In !== 1'b0) begin
            errors++;
            $display("FAIL stall_handshake cycle=%0d valid=%b ready_in=%b required=1/0", k, Valid_Out, Ready_In);
         end
         checks++;
         if ({flag_invalid, flag_overflow, flag_underflow, data_o} !== held) begin
            errors++;
            $display("FAIL stall_hold cycle=%0d got=%h required=%h", k, data_o, held[31:0]);
         end
         @(posedge clk); #1;
      end
      Ready_Out = 1'b1;
      drain(20, dok);
      checks++;
      if (to != 0 || !dok || out_cnt - out0 != 5) begin
         errors++;
         $display("FAIL backpressure_delivery got=%0d results pending=%0d required=5/0", out_cnt - out0, sb_q.size());
      end
      $display("test_backpressure done");
   endtask

   task automatic test_reset_midstream();
      bit ok1, ok2;
      int out0;
      Ready_Out = 1'b1;
      send(32'h40000000, 32'h40400000, {3'b000, 32'h40C00000}, ok1);
      send(32'h3F800000, 32'hBF800000, {3'b000, 32'hBF800000}, ok2);
      Valid_In = 1'b0;
      rst      = 1'b1;
      sb_q.delete();
      @(posedge clk); #1;
      checks++;
      if (!ok1 || !ok2 || Valid_Out !== 1'b0) begin
         errors++;
         $display("FAIL reset_flush valid=%b accepted=%b%b required=0/11", Valid_Out, ok1, ok2);
      end
      rst  = 1'b0;
      out0 = out_cnt;
      @(posedge clk); #1;
      checks++;
      if (Ready_In !== 1'b1) begin errors++; $display("FAIL ready_after_midreset got=%b required=1", Ready_In); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (Valid_Out !== 1'b0) begin
            errors++;
            $display("FAIL ghost_valid cycle=%0d got=%b required=0", k, Valid_Out);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (out_cnt != out0) begin
         errors++;
         $display("FAIL ghost_results got=%0d required=0", out_cnt - out0);
      end
      $display("test_reset_midstream done");
   endtask

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "simulation time limit");
   end

endmodule
